// File: rtl/fp32_div_seq.sv
// fp32_div_seq: multicycle IEEE-754 single-precision divider, q = a / b.
// Radix-2 restoring mantissa division, one quotient bit per clock, followed
// by a single round-to-nearest-even step. Denormal inputs flush to zero and
// no denormal results are produced. One operation in flight at a time.
module fp32_div_seq #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic [4:0]  flags
);

  localparam int CW = $clog2(QBITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(QBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Special-case outcome decided at accept time; SP_NONE means normal path.
  typedef enum logic [2:0] {
    SP_NONE = 3'd0,
    SP_NAN  = 3'd1,
    SP_DBZ  = 3'd2,
    SP_INF  = 3'd3,
    SP_ZERO = 3'd4
  } special_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        mb_q;
  logic [24:0]        rem_q;
  logic [QBITS-1:0]   quot_q;
  special_t           sp_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [31:0]        res_q;
  logic [4:0]         flags_q;

  // Operand decode
  logic [7:0]         a_exp_s, b_exp_s;
  logic               a_zero_s, b_zero_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s;
  special_t           sp_in_s;
  logic signed [9:0]  exp_in_s;
  logic [23:0]        ma_in_s, mb_in_s;

  // Divider step
  logic               rem_ge_s;
  logic [23:0]        rem_diff_s;
  logic [24:0]        rem_d;
  logic [QBITS-1:0]   quot_d;

  // Rounding
  logic [QBITS-1:0]   norm_s;
  logic signed [9:0]  exp1_s, exp2_s;
  logic [23:0]        mant_s;
  logic               guard_s, sticky_s, round_up_s;
  logic [24:0]        mant_r_s;
  logic [22:0]        frac_s;
  logic [31:0]        rnd_res_s;
  logic [4:0]         rnd_flags_s;

  // Unpack and classify the incoming operands; denormals count as zero.
  always_comb begin
    a_exp_s  = a[30:23];
    b_exp_s  = b[30:23];
    a_zero_s = (a_exp_s == 8'd0);
    b_zero_s = (b_exp_s == 8'd0);
    a_nan_s  = (a_exp_s == 8'hFF) && (a[22:0] != 23'd0);
    b_nan_s  = (b_exp_s == 8'hFF) && (b[22:0] != 23'd0);
    a_inf_s  = (a_exp_s == 8'hFF) && (a[22:0] == 23'd0);
    b_inf_s  = (b_exp_s == 8'hFF) && (b[22:0] == 23'd0);
    ma_in_s  = a_zero_s ? 24'd0 : {1'b1, a[22:0]};
    mb_in_s  = b_zero_s ? 24'd0 : {1'b1, b[22:0]};
    exp_in_s = $signed({2'b00, a_exp_s}) - $signed({2'b00, b_exp_s}) + 10'sd127;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      sp_in_s = SP_NAN;
    end else if (a_inf_s) begin
      sp_in_s = SP_INF;
    end else if (b_zero_s) begin
      sp_in_s = SP_DBZ;
    end else if (a_zero_s || b_inf_s) begin
      sp_in_s = SP_ZERO;
    end else begin
      sp_in_s = SP_NONE;
    end
  end

  // One restoring step. The remainder is kept pre-doubled, so the first
  // comparison is ma against mb and the quotient MSB carries weight 2^0;
  // this keeps the remainder below 2*mb for any ma/mb in (0.5, 2).
  always_comb begin
    rem_ge_s   = (rem_q >= {1'b0, mb_q});
    rem_diff_s = 24'(rem_q - {1'b0, mb_q});
    rem_d      = rem_ge_s ? {rem_diff_s, 1'b0} : {rem_q[23:0], 1'b0};
    quot_d     = {quot_q[QBITS-2:0], rem_ge_s};
  end

  // Normalise, round to nearest-even, range-check, then apply specials.
  always_comb begin
    norm_s     = quot_q[QBITS-1] ? quot_q : {quot_q[QBITS-2:0], 1'b0};
    exp1_s     = quot_q[QBITS-1] ? exp_q : (exp_q - 10'sd1);
    mant_s     = norm_s[QBITS-1 -: 24];
    guard_s    = norm_s[QBITS-25];
    sticky_s   = (|norm_s[QBITS-26:0]) | (rem_q != 25'd0);
    round_up_s = guard_s & (sticky_s | mant_s[0]);
    mant_r_s   = {1'b0, mant_s} + {24'd0, round_up_s};
    exp2_s     = mant_r_s[24] ? (exp1_s + 10'sd1) : exp1_s;
    frac_s     = mant_r_s[24] ? mant_r_s[23:1] : mant_r_s[22:0];
    if (exp2_s >= 10'sd255) begin
      rnd_res_s   = {sign_q, 8'hFF, 23'd0};
      rnd_flags_s = 5'b00101;
    end else if (exp2_s <= 10'sd0) begin
      rnd_res_s   = {sign_q, 31'd0};
      rnd_flags_s = 5'b00011;
    end else begin
      rnd_res_s   = {sign_q, exp2_s[7:0], frac_s};
      rnd_flags_s = {4'b0000, guard_s | sticky_s};
    end
    case (sp_q)
      SP_NAN: begin
        rnd_res_s   = 32'h7FC00000;
        rnd_flags_s = 5'b10000;
      end
      SP_DBZ: begin
        rnd_res_s   = {sign_q, 8'hFF, 23'd0};
        rnd_flags_s = 5'b01000;
      end
      SP_INF: begin
        rnd_res_s   = {sign_q, 8'hFF, 23'd0};
        rnd_flags_s = 5'b00000;
      end
      SP_ZERO: begin
        rnd_res_s   = {sign_q, 31'd0};
        rnd_flags_s = 5'b00000;
      end
      default: begin
        rnd_res_s   = rnd_res_s;
        rnd_flags_s = rnd_flags_s;
      end
    endcase
  end

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      sign_q      <= 1'b0;
      exp_q       <= 10'sd0;
      mb_q        <= 24'd0;
      rem_q       <= 25'd0;
      quot_q      <= {QBITS{1'b0}};
      sp_q        <= SP_NONE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= 32'd0;
      flags_q     <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sign_q     <= a[31] ^ b[31];
            exp_q      <= exp_in_s;
            mb_q       <= mb_in_s;
            rem_q      <= {1'b0, ma_in_s};
            quot_q     <= {QBITS{1'b0}};
            sp_q       <= sp_in_s;
            cnt_q      <= {CW{1'b0}};
            in_ready_q <= 1'b0;
            state_q    <= S_ITER;
          end
        end
        S_ITER: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          if (cnt_q == LAST_CNT) begin
            state_q <= S_ROUND;
          end else begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_ROUND: begin
          res_q       <= rnd_res_s;
          flags_q     <= rnd_flags_s;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = res_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed testbench for fp32_div_seq with hand-computed expected results.
module tb_fp32_div_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic [4:0]  flags;

  int n_vec;
  int n_err;

  fp32_div_seq #(.QBITS(26)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // Wait (bounded) for in_ready, present one operation, then scramble a/b.
  task automatic send(input logic [31:0] av, input logic [31:0] bv);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check_val("ready_wait", {31'd0, in_ready}, 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom();
    b = $urandom();
  endtask

  // Count edges after acceptance until out_valid; note in_ready while busy.
  task automatic wait_out(output int lat, output bit busy_bad);
    lat = 0;
    busy_bad = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid && in_ready) busy_bad = 1'b1;
    end while (!out_valid && lat < 100);
  endtask

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] eq, input logic [4:0] ef);
    int lat;
    bit busy_bad;
    out_ready = 1'b1;
    send(av, bv);
    wait_out(lat, busy_bad);
    check_val({tag, "_lat"}, lat, 32'd27);
    check_val({tag, "_q"}, q, eq);
    check_val({tag, "_flags"}, {27'd0, flags}, {27'd0, ef});
    check_val({tag, "_busy_rdy"}, {31'd0, busy_bad}, 32'd0);
    @(posedge clk); #1;
    check_val({tag, "_ov_after"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_rdy_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    bit busy_bad;
    bit seen;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 32'd0;
    b = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_q", q, 32'd0);
    check_val("rst_flags", {27'd0, flags}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Main function and boundary cases
    run("c1_1000_5",   32'h447A0000, 32'h40A00000, 32'h43480000, 5'b00000);
    run("c2_1_9",      32'h3F800000, 32'h41100000, 32'h3DE38E39, 5'b00001);
    run("c3_rne",      32'h3EC00000, 32'h3ECCCCCD, 32'h3F700000, 5'b00001);
    run("c4_dbz",      32'h40C00000, 32'h00000000, 32'h7F800000, 5'b01000);
    run("c4_0_0",      32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000);
    run("c4_ovf",      32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101);
    run("c4_unf",      32'h00800000, 32'h4B000000, 32'h00000000, 5'b00011);
    run("neg_6_9",     32'hC0C00000, 32'h41100000, 32'hBF2AAAAB, 5'b00001);
    run("inf_fin",     32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000);
    run("fin_inf",     32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000);
    run("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000);

    // Backpressure: hold DONE for 10 cycles while poking in_valid
    out_ready = 1'b0;
    send(32'h447A0000, 32'h40A00000);
    wait_out(lat, busy_bad);
    check_val("bp_lat", lat, 32'd27);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 32'h3F800000;
      b = 32'h40000000;
      @(posedge clk); #1;
      check_val("bp_q", q, 32'h43480000);
      check_val("bp_flags", {27'd0, flags}, 32'd0);
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_ov_after", {31'd0, out_valid}, 32'd0);
    check_val("bp_rdy_after", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_val("bp_no_queued", {31'd0, seen}, 32'd0);

    // Reset in the middle of ITER
    send(32'h447A0000, 32'h40A00000);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_q", q, 32'd0);
    check_val("mid_rst_flags", {27'd0, flags}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_val("mid_rst_no_result", {31'd0, seen}, 32'd0);
    run("c6_6_9", 32'h40C00000, 32'h41100000, 32'h3F2AAAAB, 5'b00001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
